// File: rtl/spi_bypass_pkg.sv
// spi_bypass_pkg: shared types and constants for the SPI bypass sequencer.
//   state_t  - sequencer states
//   MODE0..3 - {CPOL,CPHA} encodings
//   CPOL_BIT, CPHA_BIT - bit positions inside a spi_mode value
package spi_bypass_pkg;
   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;
   localparam int CPOL_BIT = 1;
   localparam int CPHA_BIT = 0;
endpackage

// File: rtl/spi_bypass_sequencer_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags and flush.
//   clk, reset (async, active-high), flush (sync clear)
//   push/wr_data - write side; a push on a full FIFO succeeds only with a pop
//   pop/rd_data  - read side; rd_data is the current head
//   full, empty, count - occupancy status
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic full_q, full_d, empty_q, empty_d, do_push, do_pop;
   always_comb begin
      do_pop = pop && !empty_q && !flush;
      do_push = push && (!full_q || do_pop) && !flush;
      wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
      rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
      count_d = flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      full_d = count_d == (AW+1)'(DEPTH);
      empty_d = count_d == '0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         full_q <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         full_q <= full_d;
         empty_q <= empty_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end
   assign rd_data = mem_q[rd_ptr_q];
   assign full = full_q;
   assign empty = empty_q;
   assign count = count_q;
endmodule

// File: rtl/spi_bypass_sequencer.sv
// spi_bypass_sequencer: queued SPI master for host bypass access to the headstage bus.
//   clk, reset (async, active-high)
//   enable, spi_mode {CPOL,CPHA}, clk_div (half-period-1), cs_gap (CS_N high-1), burst, flush
//   cmd_data/cmd_valid/cmd_ready - command FIFO push side
//   rsp_data/rsp_valid/rsp_ready - response FIFO pop side
//   busy, words_done - status
//   cs_n, sclk, mosi, miso - SPI pins
module spi_bypass_sequencer
   import spi_bypass_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [1:0]        spi_mode,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic [3:0]        cs_gap,
   input  logic              burst,
   input  logic              flush,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              busy,
   output logic [15:0]       words_done,
   output logic              cs_n,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso
);
   localparam int EW = $clog2(2 * DATA_W) + 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [DIV_W-1:0] div_q, div_d, div_cnt_q, div_cnt_d;
   logic [EW-1:0] edge_q, edge_d;
   logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d;
   logic [3:0] gap_q, gap_d;
   logic [15:0] words_q, words_d;
   logic cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d, discard_q, discard_d;
   logic [DATA_W-1:0] cmd_head;
   logic [CW-1:0] cmd_count, rsp_count;
   logic cmd_full, cmd_empty, rsp_full, rsp_empty;
   logic tick, toggle, sample, start_idle, trail_end, start_burst, rsp_push, cmd_pop;
   sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
      .clk(clk), .reset(reset), .flush(flush),
      .push(cmd_valid && !cmd_full), .wr_data(cmd_data),
      .pop(cmd_pop), .rd_data(cmd_head),
      .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
   );
   sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
      .clk(clk), .reset(reset), .flush(flush),
      .push(rsp_push), .wr_data(rx_q),
      .pop(rsp_ready), .rd_data(rsp_data),
      .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
   );
   assign tick = div_cnt_q == div_q;
   assign toggle = tick && (state_q == LEAD || (state_q == SHIFT && edge_q != EW'(2 * DATA_W)));
   // Toggle number edge_q+1 is a leading edge when odd; CPHA picks which edge samples.
   assign sample = mode_q[CPHA_BIT] ? edge_q[0] : !edge_q[0];
   assign start_idle = state_q == IDLE && enable && !flush && !cmd_empty && !rsp_full;
   assign trail_end = state_q == TRAIL && tick;
   // A response from a word that saw a flush is silently dropped.
   assign rsp_push = trail_end && !discard_q && !flush;
   // Room is judged after this word's push so a burst can never overrun the response FIFO.
   assign start_burst = trail_end && burst && enable && !flush && cmd_count != '0 &&
                        (rsp_count + CW'(rsp_push)) < CW'(FIFO_DEPTH);
   assign cmd_pop = start_idle || start_burst;
   always_comb begin
      state_d = state_q;
      mode_d = mode_q;
      div_d = div_q;
      edge_d = edge_q;
      tx_d = tx_q;
      rx_d = rx_q;
      gap_d = gap_q;
      words_d = words_q;
      cs_n_d = cs_n_q;
      sclk_d = sclk_q;
      mosi_d = mosi_q;
      discard_d = discard_q;
      div_cnt_d = (state_q inside {LEAD, SHIFT, TRAIL} && !tick) ? div_cnt_q + DIV_W'(1) : '0;
      if (toggle) begin
         sclk_d = !sclk_q;
         edge_d = edge_q + EW'(1);
         if (sample) rx_d = {rx_q[DATA_W-2:0], miso};
         else if (edge_q != EW'(2 * DATA_W - 1)) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d = tx_q << 1;
         end
      end
      case (state_q)
         IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = spi_mode[CPOL_BIT];
            mosi_d = 1'b0;
         end
         LEAD: if (tick) state_d = SHIFT;
         SHIFT: if (tick && edge_q == EW'(2 * DATA_W)) state_d = TRAIL;
         TRAIL: begin
            sclk_d = mode_q[CPOL_BIT];
            if (tick) begin
               words_d = words_q + 16'd1;
               state_d = GAP;
               cs_n_d = 1'b1;
               sclk_d = spi_mode[CPOL_BIT];
               mosi_d = 1'b0;
               gap_d = '0;
            end
         end
         GAP: begin
            sclk_d = spi_mode[CPOL_BIT];
            mosi_d = 1'b0;
            gap_d = gap_q + 4'd1;
            if (gap_q == cs_gap) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush && state_q inside {LEAD, SHIFT, TRAIL}) discard_d = 1'b1;
      // Word start: CPHA=0 puts the MSB out now, so the shifter is preloaded one bit ahead.
      if (cmd_pop) begin
         state_d = LEAD;
         mode_d = spi_mode;
         div_d = clk_div;
         edge_d = '0;
         cs_n_d = 1'b0;
         sclk_d = spi_mode[CPOL_BIT];
         discard_d = 1'b0;
         tx_d = spi_mode[CPHA_BIT] ? cmd_head : cmd_head << 1;
         mosi_d = spi_mode[CPHA_BIT] ? 1'b0 : cmd_head[DATA_W-1];
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         mode_q <= '0;
         div_q <= '0;
         div_cnt_q <= '0;
         edge_q <= '0;
         tx_q <= '0;
         rx_q <= '0;
         gap_q <= '0;
         words_q <= '0;
         cs_n_q <= 1'b1;
         sclk_q <= 1'b0;
         mosi_q <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q <= mode_d;
         div_q <= div_d;
         div_cnt_q <= div_cnt_d;
         edge_q <= edge_d;
         tx_q <= tx_d;
         rx_q <= rx_d;
         gap_q <= gap_d;
         words_q <= words_d;
         cs_n_q <= cs_n_d;
         sclk_q <= sclk_d;
         mosi_q <= mosi_d;
         discard_q <= discard_d;
      end
   end
   assign cmd_ready = !cmd_full;
   assign rsp_valid = !rsp_empty;
   assign busy = state_q != IDLE;
   assign words_done = words_q;
   assign cs_n = cs_n_q;
   assign sclk = sclk_q;
   assign mosi = mosi_q;
endmodule
